// File: rtl/xup_sfr_pkg.sv
// Shared constants for the serial frame receiver: FSM state encoding and line levels.
package xup_sfr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } sfr_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/xup_sipo_shifter.sv
// Serial-in parallel-out shift register; MSB_FIRST selects left or right shift direction.
module xup_sipo_shifter #(
  parameter int SIZE      = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            shift_en,
  input  logic            din,
  output logic [SIZE-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (shift_en) begin
      if (MSB_FIRST) q <= {q[SIZE-2:0], din};
      else           q <= {din, q[SIZE-1:1]};
    end
  end

endmodule

// File: rtl/xup_serial_frame_receiver.sv
// Framed serial receiver (start 0, SIZE data bits, stop 1) with valid/ack output handshake.
// Optional even-parity bit before the stop bit when XUP_SFR_PARITY_EN is defined.
module xup_serial_frame_receiver
  import xup_sfr_pkg::*;
#(
  parameter int SIZE      = 4,
  parameter int DELAY     = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            serial_in,
  input  logic            bit_en,
  input  logic            ack,
  output logic [SIZE-1:0] data_out,
  output logic            valid,
  output logic            busy,
  output logic            frame_err,
  output logic            overrun,
  output logic            parity_err
);

  localparam int CNT_W = $clog2(SIZE);

  // DELAY only shapes simulation timing of the original model; outputs here are zero-delay.
  if (SIZE < 2 || DELAY < 0) begin : g_bad_cfg
    $error("xup_serial_frame_receiver: SIZE must be >= 2 and DELAY >= 0");
  end

  sfr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0]  sr;
  logic             shift_en;
  logic             stop_seen, stop_good, par_ok, accept, load, drop;

  xup_sipo_shifter #(.SIZE(SIZE), .MSB_FIRST(MSB_FIRST)) u_sr (
    .clk      (clk),
    .clr      (reset),
    .shift_en (shift_en),
    .din      (serial_in),
    .q        (sr)
  );

`ifdef XUP_SFR_PARITY_EN
  logic par_bit_q;

  always_ff @(posedge clk) begin
    if (reset)                               par_bit_q <= 1'b0;
    else if (state_q == ST_PARITY && bit_en) par_bit_q <= serial_in;
  end

  assign par_ok = ~(^{sr, par_bit_q});
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_en  = 1'b0;
    stop_seen = 1'b0;
    if (bit_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (serial_in == START_BIT) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
        ST_DATA: begin
          shift_en = 1'b1;
          if (cnt_q == CNT_W'(SIZE - 1)) begin
            cnt_d = '0;
`ifdef XUP_SFR_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
`ifdef XUP_SFR_PARITY_EN
          state_d = ST_STOP;
`else
          state_d = ST_IDLE;
`endif
        end
        ST_STOP: begin
          stop_seen = 1'b1;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A bad stop bit outranks a parity mismatch; a clean frame either loads or is dropped.
  assign stop_good = stop_seen && (serial_in == STOP_BIT);
  assign accept    = stop_good && par_ok;
  assign load      = accept && (!valid || ack);
  assign drop      = accept && valid && !ack;
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_err <= stop_seen && !stop_good;
      if (load) begin
        data_out <= sr;
        valid    <= 1'b1;
      end else if (valid && ack) begin
        valid <= 1'b0;
      end
      if (drop) overrun <= 1'b1;
    end
  end

`ifdef XUP_SFR_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) parity_err <= 1'b0;
    else       parity_err <= stop_good && !par_ok;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/xup_serial_frame_receiver.md
Name: xup_serial_frame_receiver

Overview:
Serial-to-parallel frame receiver, the receive end of the library's shift-register serial link.
- Samples a framed serial stream: start bit 0, SIZE data bits, stop bit 1. Line idles high.
- One bit is sampled per bit_en strobe.
- Assembled word is presented on data_out with a valid/ack handshake.
- Flags framing errors and overruns; sits between a serializing shift register and parallel consumer logic.

Parameters:
SIZE, 4, data bits per frame (>=2)
DELAY, 3, simulation-only output delay (#DELAY) on all outputs
MSB_FIRST, 1, 1 = first data bit lands in data_out[SIZE-1] (left shift); 0 = first bit lands in data_out[0] (right shift)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
serial_in  input  1  serial line, idle high
bit_en  input  1  sample strobe; serial_in is sampled only on cycles with bit_en=1
ack  input  1  consumer accepts data_out when valid=1
data_out  output  SIZE  last accepted frame
valid  output  1  data_out holds unconsumed data
busy  output  1  frame in progress (state != IDLE)
frame_err  output  1  one-cycle pulse: stop bit sampled as 0
overrun  output  1  sticky: a completed frame was dropped because valid was still 1
parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 without the parity feature

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - state=IDLE, shift reg=0, bit counter=0.
  - data_out=0, valid=0, busy=0, frame_err=0, overrun=0, parity_err=0.
- States: IDLE, DATA, (PARITY), STOP. All transitions occur only on bit_en=1 cycles, except the ack handling below.
- IDLE: on bit_en & serial_in=0 -> DATA, cnt=0. serial_in=1 -> stay.
- DATA, on each bit_en:
  - MSB_FIRST=1: sr <= {sr[SIZE-2:0], serial_in}.
  - MSB_FIRST=0: sr <= {serial_in, sr[SIZE-1:1]}.
  - cnt increments; at cnt==SIZE-1 -> STOP (or PARITY if enabled).
- STOP, on bit_en -> IDLE, with the sampled stop bit handled as follows:
  - Sampled 1, valid=0, or valid=1 with ack=1 that same cycle: data_out<=sr, valid<=1.
  - Sampled 1, valid=1 and ack=0: data_out unchanged, overrun<=1 (sticky until reset).
  - Sampled 0: frame_err pulses for 1 cycle, data discarded, valid unchanged.
- Latency: valid rises on the clock edge that samples the stop bit (visible the following cycle, plus DELAY).
- ack: valid & ack clears valid next edge, unless a new frame loads in the same edge (the new frame wins, valid stays 1). ack with valid=0 is ignored.
- bit_en=0 cycles hold all state; no timeout.
- Start-bit glitches are not filtered. A start bit immediately after the stop bit is legal (back-to-back frames).
- Reset mid-frame aborts the frame silently; no error flags.

Optional Feature:
Macro XUP_SFR_PARITY_EN.
- Defined: PARITY state is inserted between DATA and STOP and samples one even-parity bit (XOR of data bits plus parity bit must be 0).
  - On mismatch: parity_err pulses 1 cycle when STOP is sampled, and the frame is discarded (no valid, no overrun).
  - frame_err takes precedence if the stop bit is also 0; parity_err is then not pulsed.
- Undefined: no PARITY state; parity_err tied 0.

Decomposition:
- Package xup_sfr_pkg holds:
  - state encoding constants: ST_IDLE, ST_DATA, ST_PARITY, ST_STOP (2-bit);
  - LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
- One sub-module, xup_sipo_shifter: SIZE/MSB_FIRST parameterised shift register with shift-enable and clear, instantiated for sr.
- Counter, FSM and handshake stay in the top module.

Test Plan:
1. Reset held 2 cycles, line high, bit_en=1 continuously -> all outputs 0, busy=0 for 10 cycles.
2. SIZE=4, MSB_FIRST=1, bits 0,1,0,1,1,1 (start, data 1011, stop) on consecutive bit_en cycles -> data_out=4'b1011, valid=1; ack=1 one cycle -> valid=0.
3. Same stream, MSB_FIRST=0 -> data_out=4'b1101. Repeat with bit_en every 3rd cycle -> identical result.
4. Stop bit 0 -> frame_err pulses exactly 1 cycle, valid stays 0. A following good frame 0,0,1,1,0,1 -> data_out=4'b0110.
5. Two good frames (1011 then 0110), no ack -> data_out=1011, overrun=1. Repeat with ack asserted in the stop-bit cycle of frame 2 -> data_out=0110, valid=1, overrun=0.
6. Reset after 2 data bits -> busy=0 next cycle, no flags, next frame correct. With XUP_SFR_PARITY_EN: data 1011, parity 1 -> valid; parity 0 -> parity_err pulse, valid=0.
